spmv_csr_engine: RTL and testbench
==================================

# spmv_csr_engine

Parametrised CSR sparse matrix–vector multiply engine for the SpMV accelerator. It is the next-generation core: the row count, index width and data width are parameters, and nonzeros arrive on a valid/ready stream instead of a fixed multi-cycle state loop. It runs a two-stage multiply-accumulate at one nonzero per cycle, with saturating signed integer accumulation, sticky overflow and malformed-pointer flags, and a done pulse. It sits between the matrix/vector memory fetch unit and the result write-back logic.

## Interface
- N_ROWS, 16: matrix rows; there are N_ROWS+1 row pointers.
- IDX_W, 8: width of each row pointer, the nonzero count and the element index.
- DATA_W, 16: signed width of the matrix value and the vector operand.
- ACC_W, 32: signed accumulator width. Must be ≥ 2*DATA_W; elaboration error otherwise.

Ports:
- i_clk  in  1  clock; reset i_rstn, asynchronous, active-low.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_nnz_total  in  IDX_W  number of nonzeros; captured on start.
- i_row_ptr  in  (N_ROWS+1)*IDX_W  CSR row pointers; pointer r is at bits [r*IDX_W +: IDX_W]; captured on start.
- i_val_valid  in  1  nonzero element valid.
- i_val_a  in  DATA_W  signed matrix value.
- i_val_x  in  DATA_W  signed gathered vector element.
- o_val_ready  out  1  engine accepts an element this cycle.
- o_state  out  3  current state.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_count  out  IDX_W  number of elements accepted so far.
- o_result  out  N_ROWS*ACC_W  row accumulators; row r is at bits [r*ACC_W +: ACC_W].
- o_sat  out  N_ROWS  sticky per-row saturation flags.
- o_err  out  1  sticky flag: an element was dropped (no owning row).

## Operation
- States: IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4. Other encodings go to IDLE.
- IDLE: on i_start=1, capture i_row_ptr and i_nnz_total, then go to CLEAR.
- CLEAR: lasts one cycle. Zeros o_result, o_sat, o_err and o_count, then goes to RUN.
- RUN: o_val_ready = (o_count < nnz_total).
  - An element is accepted when i_val_valid && o_val_ready, and its index k is the current o_count.
  - When o_count == nnz_total, go to DRAIN. This check happens after the edge of the last accept, or immediately if nnz_total = 0.
- Row lookup (combinational): the owning row is the lowest r with row_ptr[r] ≤ k < row_ptr[r+1].
  - Rows with equal successive pointers (empty rows) are skipped.
  - If no row matches, the element is dropped, o_err is set, and o_count still increments.
- Stage 1: register the full-precision product a*x (2*DATA_W, sign-extended to ACC_W), the row index and a valid bit.
- Stage 2: acc[row] ← sat(acc[row] + product).
  - On overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set o_sat[row].
  - The read-modify-write completes in one cycle, so back-to-back elements to the same row accumulate correctly with no stall.
- DRAIN: lasts one cycle. Flushes stage 1, then goes to DONE.
- DONE: o_done=1 for one cycle, then go to IDLE.
- i_start outside IDLE is ignored.
- Results, flags and o_count hold in IDLE until the next CLEAR.
- Reset, including mid-operation: state=IDLE and all outputs 0. The pipeline valid bit is cleared, so no partial update survives.

## Timing
- i_start sampled at edge T → CLEAR during T..T+1 → RUN from T+1.
  - o_val_ready is first high in the cycle after T+1.
- Element accepted at edge E → product registered at E → accumulator updated at edge E+1.
- Last accept at edge E → DRAIN during E..E+1 → DONE during E+1..E+2. o_done is high in that cycle and o_result is final.
- nnz_total = 0 → o_done is high in the cycle after edge T+3, and o_val_ready never rises.
- Throughput: one element per cycle while valid is held.
- Stalls (valid low) insert bubbles with no other effect.

## Structure
- Package spmv_pkg contains:
  - the state enum (IDLE..DONE);
  - the ACC max/min constants as functions of ACC_W;
  - a sat_add function.
- Sub-module spmv_row_lookup: a parametrised comparator array mapping index k and the captured pointers to (row, hit).
- The top level holds the FSM, the two pipeline stages and the accumulator array.

## Test plan
- Basic run, defaults:
  - Stimulus: row_ptr = {0,2,3,3,5,5…5}, nnz = 5; elements (2,3), (4,−1), (5,5), (1,1), (−2,7) sent back-to-back.
  - Response: acc0 = 2, acc1 = 25, acc2 = 0, acc3 = −13, all other rows 0; o_done is high in the cycle after edge E+1; o_sat = 0, o_err = 0.
- Backpressure: the same data with i_val_valid toggled 1-0-0-1… → identical results, o_count = 5, o_done pulses once.
- nnz = 0: start → no ready; o_done is high in the cycle after T+3; all results 0.
- Saturation: row 0 receives three elements (32767, 32767) → acc0 = 2147483647 and o_sat[0] = 1, other flags 0.
- Reset mid-RUN: drop i_rstn after 2 accepts → all outputs 0, state IDLE; a new start on the basic-run data reproduces the basic-run results.
- Malformed pointers: row_ptr[N_ROWS] = 3 with nnz = 5 → elements 3 and 4 are dropped, o_err = 1, o_count = 5, o_done still pulses.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared types and helpers for the CSR SpMV engine.
//   spmv_state_e : engine FSM state encoding (IDLE..DONE)
//   acc_max/min  : saturation bounds of a w-bit signed accumulator
//   sat_add      : w-bit saturating signed add, reports clamping
package spmv_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } spmv_state_e;

  // Widest accumulator the helpers support; callers sign-extend into this.
  localparam int unsigned MaxAccW = 64;

  typedef logic signed [MaxAccW-1:0] acc_wide_t;

  typedef struct packed {
    logic      sat;
    acc_wide_t sum;
  } sat_sum_t;

  function automatic acc_wide_t acc_max(int unsigned w);
    logic [MaxAccW-1:0] one;
    one = {{(MaxAccW-1){1'b0}}, 1'b1};
    return acc_wide_t'((one << (w - 1)) - one);
  endfunction

  function automatic acc_wide_t acc_min(int unsigned w);
    return ~acc_max(w);
  endfunction

  // Operands must already hold sign-extended w-bit values.
  function automatic sat_sum_t sat_add(acc_wide_t a, acc_wide_t b, int unsigned w);
    logic signed [MaxAccW:0] s;
    logic signed [MaxAccW:0] hi;
    logic signed [MaxAccW:0] lo;
    acc_wide_t               mx;
    acc_wide_t               mn;
    sat_sum_t                r;
    mx    = acc_max(w);
    mn    = acc_min(w);
    hi    = {mx[MaxAccW-1], mx};
    lo    = {mn[MaxAccW-1], mn};
    s     = {a[MaxAccW-1], a} + {b[MaxAccW-1], b};
    r.sat = 1'b0;
    r.sum = s[MaxAccW-1:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = mx;
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = mn;
    end
    return r;
  endfunction

endpackage

// File: rtl/spmv_csr_engine_row_lookup.sv
// Maps a nonzero index k to its owning CSR row.
//   i_k       : nonzero index
//   i_row_ptr : N_ROWS+1 packed row pointers, pointer r at [r*IDX_W +: IDX_W]
//   o_row     : lowest r with row_ptr[r] <= k < row_ptr[r+1]
//   o_hit     : some row owns k
module spmv_row_lookup #(
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ROW_W  = 4
) (
  input  logic [IDX_W-1:0]            i_k,
  input  logic [(N_ROWS+1)*IDX_W-1:0] i_row_ptr,
  output logic [ROW_W-1:0]            o_row,
  output logic                        o_hit
);

  // Scan downwards so the last match written is the lowest row; empty rows never match.
  always_comb begin
    o_row = '0;
    o_hit = 1'b0;
    for (int r = int'(N_ROWS) - 1; r >= 0; r--) begin
      if ((i_row_ptr[r*IDX_W +: IDX_W] <= i_k) && (i_k < i_row_ptr[(r+1)*IDX_W +: IDX_W])) begin
        o_row = ROW_W'(r);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spmv_csr_engine.sv
// CSR sparse matrix-vector multiply engine: one nonzero per cycle over a valid/ready
// stream, two-stage MAC with saturating signed row accumulators.
//   i_clk/i_rstn             : clock, asynchronous active-low reset
//   i_start                  : start request (IDLE only)
//   i_nnz_total, i_row_ptr   : job shape, captured on start
//   i_val_valid/a/x, o_val_ready : nonzero stream (matrix value, gathered vector value)
//   o_state, o_busy, o_done  : FSM state, busy level, one-cycle completion pulse
//   o_count                  : elements accepted this job
//   o_result, o_sat, o_err   : row accumulators, sticky saturation and dropped-element flags
module spmv_csr_engine
  import spmv_pkg::*;
#(
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [IDX_W-1:0]            i_nnz_total,
  input  logic [(N_ROWS+1)*IDX_W-1:0] i_row_ptr,
  input  logic                        i_val_valid,
  input  logic signed [DATA_W-1:0]    i_val_a,
  input  logic signed [DATA_W-1:0]    i_val_x,
  output logic                        o_val_ready,
  output logic [2:0]                  o_state,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [IDX_W-1:0]            o_count,
  output logic [N_ROWS*ACC_W-1:0]     o_result,
  output logic [N_ROWS-1:0]           o_sat,
  output logic                        o_err
);

  localparam int unsigned RowW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  if (ACC_W < 2 * DATA_W || ACC_W > MaxAccW) begin : g_bad_acc_w
    $error("spmv_csr_engine: ACC_W must be >= 2*DATA_W and <= %0d", MaxAccW);
  end

  spmv_state_e                 r_state;
  logic                        r_busy;
  logic                        r_done;
  logic [(N_ROWS+1)*IDX_W-1:0] r_row_ptr;
  logic [IDX_W-1:0]            r_nnz;
  logic [IDX_W-1:0]            r_count;
  logic                        r_err;
  logic [N_ROWS-1:0]           r_sat;
  logic signed [ACC_W-1:0]     r_acc [N_ROWS];
  logic                        r_s1_valid;
  logic signed [ACC_W-1:0]     r_s1_prod;
  logic [RowW-1:0]             r_s1_row;

  logic                        w_ready;
  logic                        w_accept;
  logic                        w_run_end;
  logic [RowW-1:0]             w_row;
  logic                        w_hit;
  logic signed [2*DATA_W-1:0]  w_prod;
  sat_sum_t                    w_sum;

  assign w_ready  = (r_state == StRun) && (r_count < r_nnz);
  assign w_accept = i_val_valid && w_ready;
  assign w_prod   = i_val_a * i_val_x;
  // Leave RUN on the edge of the last accept, or straight away for an empty job.
  assign w_run_end = (r_count == r_nnz) || (w_accept && (r_count + IDX_W'(1) == r_nnz));

  spmv_row_lookup #(
    .N_ROWS (N_ROWS),
    .IDX_W  (IDX_W),
    .ROW_W  (RowW)
  ) u_row_lookup (
    .i_k       (r_count),
    .i_row_ptr (r_row_ptr),
    .o_row     (w_row),
    .o_hit     (w_hit)
  );

  // Stage 2 read-modify-write is single-cycle, so same-row back-to-back needs no forwarding.
  assign w_sum = sat_add(acc_wide_t'(r_acc[r_s1_row]), acc_wide_t'(r_s1_prod), ACC_W);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_row_ptr  <= '0;
      r_nnz      <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_sat      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_row   <= '0;
      for (int r = 0; r < int'(N_ROWS); r++) r_acc[r] <= '0;
    end else begin
      r_done     <= 1'b0;
      // Dropped elements never enter the pipeline.
      r_s1_valid <= w_accept && w_hit;
      if (w_accept) begin
        r_s1_prod <= ACC_W'(w_prod);
        r_s1_row  <= w_row;
      end
      if (r_s1_valid) begin
        r_acc[r_s1_row] <= w_sum.sum[ACC_W-1:0];
        if (w_sum.sat) r_sat[r_s1_row] <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_row_ptr <= i_row_ptr;
            r_nnz     <= i_nnz_total;
            r_busy    <= 1'b1;
            r_state   <= StClear;
          end
        end
        StClear: begin
          r_count <= '0;
          r_err   <= 1'b0;
          r_sat   <= '0;
          for (int r = 0; r < int'(N_ROWS); r++) r_acc[r] <= '0;
          r_state <= StRun;
        end
        StRun: begin
          if (w_accept) begin
            r_count <= r_count + IDX_W'(1);
            if (!w_hit) r_err <= 1'b1;
          end
          if (w_run_end) r_state <= StDrain;
        end
        StDrain: begin
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    o_result = '0;
    for (int r = 0; r < int'(N_ROWS); r++) o_result[r*ACC_W +: ACC_W] = r_acc[r];
  end

  assign o_val_ready = w_ready;
  assign o_state     = r_state;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_count     = r_count;
  assign o_sat       = r_sat;
  assign o_err       = r_err;

endmodule

// File: tb/tb_spmv_csr_engine.sv
// Scoreboard bench for spmv_csr_engine: the driver pushes the expected job outcome
// computed by a plain-arithmetic CSR model; a monitor pops and compares on each o_done.
module tb_spmv_csr_engine;

  localparam int N_ROWS = 16;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam longint AccMax = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint AccMin = -AccMax - 1;

  logic                        i_clk = 1'b0;
  logic                        i_rstn = 1'b0;
  logic                        i_start = 1'b0;
  logic [IDX_W-1:0]            i_nnz_total = '0;
  logic [(N_ROWS+1)*IDX_W-1:0] i_row_ptr = '0;
  logic                        i_val_valid = 1'b0;
  logic signed [DATA_W-1:0]    i_val_a = '0;
  logic signed [DATA_W-1:0]    i_val_x = '0;
  logic                        o_val_ready;
  logic [2:0]                  o_state;
  logic                        o_busy;
  logic                        o_done;
  logic [IDX_W-1:0]            o_count;
  logic [N_ROWS*ACC_W-1:0]     o_result;
  logic [N_ROWS-1:0]           o_sat;
  logic                        o_err;

  typedef struct packed {
    logic [N_ROWS*ACC_W-1:0] res;
    logic [N_ROWS-1:0]       sat;
    logic                    err;
    logic [IDX_W-1:0]        cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ptr[N_ROWS+1];
  int   va[$];
  int   vx[$];

  spmv_csr_engine #(
    .N_ROWS (N_ROWS),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_nnz_total (i_nnz_total),
    .i_row_ptr   (i_row_ptr),
    .i_val_valid (i_val_valid),
    .i_val_a     (i_val_a),
    .i_val_x     (i_val_x),
    .o_val_ready (o_val_ready),
    .o_state     (o_state),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count),
    .o_result    (o_result),
    .o_sat       (o_sat),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: each element k belongs to the first row whose pointer range holds k.
  function automatic exp_t model(int nnz);
    exp_t   e;
    longint acc[N_ROWS];
    longint s;
    int     row;
    e = '0;
    for (int r = 0; r < N_ROWS; r++) acc[r] = 0;
    for (int k = 0; k < nnz; k++) begin
      row = -1;
      for (int r = 0; r < N_ROWS; r++) begin
        if (ptr[r] <= k && k < ptr[r+1]) begin
          row = r;
          break;
        end
      end
      if (row < 0) begin
        e.err = 1'b1;
      end else begin
        s = acc[row] + longint'(va[k]) * longint'(vx[k]);
        if (s > AccMax) begin
          s = AccMax;
          e.sat[row] = 1'b1;
        end else if (s < AccMin) begin
          s = AccMin;
          e.sat[row] = 1'b1;
        end
        acc[row] = s;
      end
    end
    for (int r = 0; r < N_ROWS; r++) e.res[r*ACC_W +: ACC_W] = ACC_W'(acc[r]);
    e.cnt = IDX_W'(nnz);
    return e;
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rstn && o_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", longint'(o_done), longint'(exp_q.size() > 0));
      end else begin
        e = exp_q.pop_front();
        for (int r = 0; r < N_ROWS; r++)
          check($sformatf("result_row%0d", r),
                longint'($signed(o_result[r*ACC_W +: ACC_W])),
                longint'($signed(e.res[r*ACC_W +: ACC_W])));
        check("sat", longint'(o_sat), longint'(e.sat));
        check("err", longint'(o_err), longint'(e.err));
        check("count", longint'(o_count), longint'(e.cnt));
      end
    end
  end

  task automatic apply_ptr();
    for (int r = 0; r <= N_ROWS; r++) i_row_ptr[r*IDX_W +: IDX_W] = IDX_W'(ptr[r]);
  endtask

  task automatic set_basic();
    ptr[0] = 0; ptr[1] = 2; ptr[2] = 3; ptr[3] = 3;
    for (int r = 4; r <= N_ROWS; r++) ptr[r] = 5;
    va = '{2, 4, 5, 1, -2};
    vx = '{3, -1, 5, 1, 7};
  endtask

  task automatic check_idle_zero(string tag);
    check({tag, "_state"}, longint'(o_state), 0);
    check({tag, "_busy"}, longint'(o_busy), 0);
    check({tag, "_done"}, longint'(o_done), 0);
    check({tag, "_ready"}, longint'(o_val_ready), 0);
    check({tag, "_count"}, longint'(o_count), 0);
    check({tag, "_sat"}, longint'(o_sat), 0);
    check({tag, "_err"}, longint'(o_err), 0);
    for (int r = 0; r < N_ROWS; r++)
      check($sformatf("%s_row%0d", tag, r), longint'($signed(o_result[r*ACC_W +: ACC_W])), 0);
  endtask

  // Called one step after a rising edge with the engine idle.
  // mode 0: valid held high; 1: valid pattern 1-0-0; 2: random valid and stray starts.
  task automatic do_run(string tag, int nnz, int mode);
    int sent;
    int budget;
    int waitc;
    bit acc_now;
    apply_ptr();
    i_nnz_total = IDX_W'(nnz);
    exp_q.push_back(model(nnz));
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    if (nnz == 0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge i_clk);
        check({tag, "_ready_nnz0"}, longint'(o_val_ready), 0);
        check({tag, "_done_early"}, longint'(o_done), 0);
      end
      @(negedge i_clk);
      check({tag, "_done_nnz0"}, longint'(o_done), 1);
      @(posedge i_clk);
      #1;
    end else begin
      sent   = 0;
      budget = 0;
      while (sent < nnz && budget < 400) begin
        case (mode)
          0:       i_val_valid = 1'b1;
          1:       i_val_valid = (budget % 3 == 0);
          default: i_val_valid = ($urandom_range(0, 2) != 0);
        endcase
        if (mode == 2) i_start = ($urandom_range(0, 3) == 0);
        i_val_a = DATA_W'(va[sent]);
        i_val_x = DATA_W'(vx[sent]);
        @(negedge i_clk);
        acc_now = i_val_valid && o_val_ready;
        @(posedge i_clk);
        #1;
        if (acc_now) sent++;
        budget++;
      end
      i_val_valid = 1'b0;
      i_start     = 1'b0;
      if (sent < nnz) begin
        check({tag, "_accepted"}, sent, nnz);
      end else begin
        @(negedge i_clk);
        check({tag, "_done_drain"}, longint'(o_done), 0);
        @(negedge i_clk);
        check({tag, "_done_pulse"}, longint'(o_done), 1);
        @(posedge i_clk);
        #1;
      end
    end
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 10) begin
      @(posedge i_clk);
      #1;
      waitc++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_pending_expect"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic gen_random(output int nnz);
    bit big;
    ptr[0] = $urandom_range(0, 1);
    for (int r = 1; r <= N_ROWS; r++) ptr[r] = ptr[r-1] + $urandom_range(0, 3);
    nnz = $urandom_range(0, ptr[N_ROWS] + 2);
    big = ($urandom_range(0, 3) == 0);
    va.delete();
    vx.delete();
    for (int k = 0; k < nnz; k++) begin
      if (big) begin
        va.push_back(($urandom_range(0, 1) != 0) ? 32767 : -32768);
        vx.push_back(($urandom_range(0, 1) != 0) ? 32767 : -32768);
      end else begin
        va.push_back(int'($urandom_range(0, 65535)) - 32768);
        vx.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
    end
  endtask

  initial begin
    int sent;
    int budget;
    int nnz;
    bit acc_now;

    i_rstn = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_idle_zero("reset");
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    set_basic();
    do_run("basic", 5, 0);
    do_run("backpressure", 5, 1);
    do_run("nnz0", 0, 0);

    ptr[0] = 0;
    for (int r = 1; r <= N_ROWS; r++) ptr[r] = 3;
    va = '{32767, 32767, 32767};
    vx = '{32767, 32767, 32767};
    do_run("saturate", 3, 0);

    // Reset in the middle of RUN, then repeat the basic job.
    set_basic();
    apply_ptr();
    i_nnz_total = IDX_W'(5);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    sent   = 0;
    budget = 0;
    while (sent < 2 && budget < 20) begin
      i_val_valid = 1'b1;
      i_val_a = DATA_W'(va[sent]);
      i_val_x = DATA_W'(vx[sent]);
      @(negedge i_clk);
      acc_now = o_val_ready;
      @(posedge i_clk);
      #1;
      if (acc_now) sent++;
      budget++;
    end
    check("midrun_accepts", sent, 2);
    i_val_valid = 1'b0;
    i_rstn = 1'b0;
    #1;
    check_idle_zero("midrun_reset");
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    do_run("after_reset", 5, 0);

    ptr[0] = 0;
    ptr[1] = 2;
    for (int r = 2; r <= N_ROWS; r++) ptr[r] = 3;
    do_run("malformed", 5, 0);

    for (int i = 0; i < 40; i++) begin
      gen_random(nnz);
      do_run($sformatf("rand%0d", i), nnz, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
